// File: rtl/program_loader.sv
// Streams 3-bit chunks into 9-bit words, writes them to CPU RAM, then enables the PC.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum chunk (adds CHK/ERR states).
module program_loader #(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned CHUNK_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  RAM_Write_Data,
  output logic [ADDR_W-1:0]  RAM_Write_Address,
  output logic               RAM_Write_Enable,
  output logic               PC_Enable,
  output logic               busy,
  output logic               error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLen, StRecv, StWrite, StChk, StRun, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLen, StRecv, StWrite, StRun} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CHUNK_W-1:0]  n_q, n_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                accept;
`ifdef LOADER_CHECKSUM_EN
  logic [CHUNK_W-1:0]  csum_q, csum_d;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle: if (start) state_d = StLen;
      StLen: begin
        if (accept) begin
          n_d     = in_data;
          addr_d  = '0;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (accept) begin
          // MSB-first: the first chunk of a word ends up in the top bits
          word_d = {word_q[DATA_W-CHUNK_W-1:0], in_data};
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (cnt_q == 2'd2) begin
            cnt_d   = '0;
            state_d = StWrite;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      StWrite: begin
        if (addr_q == ADDR_W'(n_q)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StRun;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = StRecv;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: if (accept) state_d = (in_data == csum_q) ? StRun : StErr;
      StErr: if (start) state_d = StLen;
`endif
      StRun: if (start) state_d = StLen;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Outputs decode the state register only, so they never depend on same-cycle inputs
  always_comb begin
    in_ready         = 1'b0;
    RAM_Write_Enable = 1'b0;
    PC_Enable        = 1'b0;
    busy             = 1'b0;
    error            = 1'b0;
    unique case (state_q)
      StLen, StRecv: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StWrite: begin
        RAM_Write_Enable = 1'b1;
        busy             = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StErr: error = 1'b1;
`endif
      StRun: PC_Enable = 1'b1;
      default: ;
    endcase
  end

  assign RAM_Write_Data    = word_q;
  assign RAM_Write_Address = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; RAM contents checked against a word-level model.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [2:0] in_data;
  logic       in_ready, RAM_Write_Enable, PC_Enable, busy, error;
  logic [8:0] RAM_Write_Data;
  logic [2:0] RAM_Write_Address;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] words [8];
  logic [8:0] model_mem [8] = '{default: 9'd0};
  logic [8:0] obs_mem [8] = '{default: 9'd0};
  int         log_addr [$];
  logic [8:0] log_data [$];

  program_loader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .RAM_Write_Data    (RAM_Write_Data),
    .RAM_Write_Address (RAM_Write_Address),
    .RAM_Write_Enable  (RAM_Write_Enable),
    .PC_Enable         (PC_Enable),
    .busy              (busy),
    .error             (error)
  );

  always #5 clk = ~clk;

  // CPU RAM stand-in: one entry per cycle the strobe is high
  always @(negedge clk) begin
    if (RAM_Write_Enable === 1'b1) begin
      log_addr.push_back(int'(RAM_Write_Address));
      log_data.push_back(RAM_Write_Data);
      obs_mem[RAM_Write_Address] <= RAM_Write_Data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_chunk(input logic [2:0] c, input bit gap);
    int budget;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 3'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = c;
    budget   = 0;
    while (in_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checks++;
    if (budget >= 20) begin
      errors++;
      $display("FAIL chunk_accept: in_ready stayed %b, required 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic do_load(input int n, input bit gap, input bit bad_csum);
    int         base;
    logic [2:0] cs;
    logic [2:0] ch;
    bit         exp_err;
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL start_ready: in_ready=%b required 1", in_ready);
    end
    checks++;
    if (PC_Enable !== 1'b0 || error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_state: pc=%b err=%b busy=%b required 0 0 1", PC_Enable, error, busy);
    end
    base = log_addr.size();
    cs   = 3'd0;
    send_chunk(3'(n), gap);
    for (int w = 0; w <= n; w++) begin
      for (int c = 0; c < 3; c++) begin
        ch = words[w][8-3*c -: 3];
        cs = cs ^ ch;
        send_chunk(ch, gap);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (RAM_Write_Enable !== 1'b1) begin
      errors++; $display("FAIL write_latency: we=%b required 1", RAM_Write_Enable);
    end
`ifdef LOADER_CHECKSUM_EN
    exp_err = bad_csum;
    send_chunk(bad_csum ? (cs ^ 3'b011) : cs, gap);
    @(negedge clk);
    in_valid = 1'b0;
`else
    exp_err = 1'b0;
    @(negedge clk);
`endif
    checks++;
    if (PC_Enable !== !exp_err || error !== exp_err || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_end: pc=%b err=%b busy=%b rdy=%b required %b %b 0 0",
               PC_Enable, error, busy, in_ready, !exp_err, exp_err);
    end
    for (int i = 0; i <= n; i++) model_mem[i] = words[i];
    checks++;
    if (log_addr.size() - base != n + 1) begin
      errors++;
      $display("FAIL write_count: got %0d writes required %0d", log_addr.size() - base, n + 1);
    end else begin
      for (int i = 0; i <= n; i++) begin
        checks++;
        if (log_addr[base+i] != i || log_data[base+i] !== words[i]) begin
          errors++;
          $display("FAIL write_%0d: addr=%0d data=%h required addr=%0d data=%h",
                   i, log_addr[base+i], log_data[base+i], i, words[i]);
        end
      end
    end
    for (int a = 0; a < 8; a++) begin
      checks++;
      if (obs_mem[a] !== model_mem[a]) begin
        errors++; $display("FAIL ram_%0d: got %h required %h", a, obs_mem[a], model_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 0 || RAM_Write_Enable !== 0 || PC_Enable !== 0 || busy !== 0 || error !== 0) begin
      errors++;
      $display("FAIL reset_strobes: rdy=%b we=%b pc=%b busy=%b err=%b required all 0",
               in_ready, RAM_Write_Enable, PC_Enable, busy, error);
    end
    checks++;
    if (RAM_Write_Data !== 9'd0 || RAM_Write_Address !== 3'd0) begin
      errors++;
      $display("FAIL reset_bus: data=%h addr=%h required 0 0", RAM_Write_Data, RAM_Write_Address);
    end
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 3'b101;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL idle_ignore: rdy=%b busy=%b writes=%0d required 0 0 0",
               in_ready, busy, log_addr.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_seven_word();
    words[0] = 9'h184; words[1] = 9'h024; words[2] = 9'h084; words[3] = 9'h042;
    words[4] = 9'h198; words[5] = 9'h00F; words[6] = 9'h102;
    do_load(6, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    words[0] = 9'h1FF;
    do_load(0, 1'b1, 1'b0);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_mismatch();
    words[0] = 9'h0A5;
    do_load(0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1 || PC_Enable !== 1'b0) begin
      errors++; $display("FAIL err_hold: err=%b pc=%b required 1 0", error, PC_Enable);
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    int base;
    words[0] = 9'($urandom);
    words[1] = 9'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base  = log_addr.size();
    send_chunk(3'd2, 1'b0);
    for (int c = 0; c < 3; c++) send_chunk(words[0][8-3*c -: 3], 1'b0);
    for (int c = 0; c < 2; c++) send_chunk(words[1][8-3*c -: 3], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 0 || in_ready !== 0 || RAM_Write_Enable !== 0 || PC_Enable !== 0 ||
        RAM_Write_Address !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b rdy=%b we=%b pc=%b addr=%0d required 0 0 0 0 0",
               busy, in_ready, RAM_Write_Enable, PC_Enable, RAM_Write_Address);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    model_mem[0] = words[0];
    checks++;
    if (log_addr.size() != base + 1 || log_data[base] !== words[0]) begin
      errors++;
      $display("FAIL mid_reset_writes: writes=%0d required %0d", log_addr.size() - base, 1);
    end
    checks++;
    if (obs_mem[0] !== model_mem[0] || obs_mem[1] !== model_mem[1]) begin
      errors++;
      $display("FAIL mid_reset_ram: ram0=%h ram1=%h required %h %h",
               obs_mem[0], obs_mem[1], model_mem[0], model_mem[1]);
    end
  endtask

  task automatic test_reload();
    for (int i = 0; i < 8; i++) words[i] = 9'($urandom);
    do_load(3, 1'b0, 1'b0);
    words[0] = 9'h007;
    do_load(0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 8; i++) words[i] = 9'($urandom);
      do_load(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_seven_word();
    test_stall();
`ifdef LOADER_CHECKSUM_EN
    test_mismatch();
`endif
    test_reset_mid_load();
    test_reload();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
